// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - de-skews systolic array column streams into tagged rows behind a FWFT row FIFO
module systolic_drain #(
  parameter int N          = 32,
  parameter int DW         = 32,
  parameter int ROWS       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N-1:0]            in_valid,
  input  logic [N*DW-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DW-1:0]         out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    skew_err
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = RW + N * DW;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  state_t            state, state_nx;
  logic [N-1:0]      av;
  logic [N*DW-1:0]   ad;
  logic              row_hit, partial, active, accept_start;
  logic              push, pop, full;
  logic [CW-1:0]     row_cnt;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  // Column j needs N-1-j stages so all columns of a row line up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign av[j]             = in_valid[j];
      assign ad[j*DW +: DW]    = in_data[j*DW +: DW];
    end else begin : g_dly
      logic [D-1:0]  v_sr;
      logic [DW-1:0] d_sr [D];
      always_ff @(posedge clk) begin
        d_sr[0] <= in_data[j*DW +: DW];
        for (int k = 1; k < D; k++) d_sr[k] <= d_sr[k-1];
        if (rst) begin
          v_sr <= '0;
        end else begin
          v_sr[0] <= in_valid[j];
          for (int k = 1; k < D; k++) v_sr[k] <= v_sr[k-1];
        end
      end
      assign av[j]          = v_sr[D-1];
      assign ad[j*DW +: DW] = d_sr[D-1];
    end
  end

  assign row_hit      = &av;
  assign partial      = (|av) && !row_hit;
  assign active       = (state == S_ACTIVE);
  assign accept_start = (state == S_IDLE) && start;
  assign busy         = (state != S_IDLE);

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign push      = active && row_hit && (!full || pop);

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[N*DW-1:0] : '0;
  assign out_row  = out_valid ? head[EW-1 -: RW] : '0;
  assign out_last = out_valid && (head[EW-1 -: RW] == LAST_ROW);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {row_cnt[RW-1:0], ad};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_ACTIVE;
      S_ACTIVE: if (row_hit && row_cnt == LAST_CNT) state_nx = S_FLUSH;
      S_FLUSH:  if (count == '0) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Dropped rows still advance the counter so the gap shows up in out_row.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FLUSH) && (count == '0);
      if (accept_start) begin
        row_cnt  <= '0;
        overflow <= 1'b0;
        skew_err <= 1'b0;
      end else if (active) begin
        if (row_hit) begin
          row_cnt <= row_cnt + 1'b1;
          if (full && !pop) overflow <= 1'b1;
        end
        if (partial) skew_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side collector for the systolic matrix-multiply array. The array emits result rows from its south edge one element per column per cycle. Column j lags column 0 by j cycles, mirroring the staggered injection on the input side. This block de-skews those column streams into whole result rows, tags each row with its index, and buffers rows in a small FIFO. The buffered rows are presented to the downstream writeback with a valid/ready handshake.

## Interface
- N, 32, array width (number of columns / elements per row)
- DW, 32, bits per result element
- ROWS, 32, result rows per tile
- FIFO_DEPTH, 4, row FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin draining one tile; accepted only in IDLE
- in_valid  in  N  per-column element valid from array south edge
- in_data  in  N*DW  per-column element; column j at bits [j*DW +: DW]
- out_valid  out  1  row available
- out_ready  in  1  downstream accepts row
- out_data  out  N*DW  de-skewed row, same column packing as in_data
- out_row  out  $clog2(ROWS)  row index of out_data
- out_last  out  1  out_row == ROWS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, tile fully drained
- overflow  out  1  sticky: row dropped because FIFO full
- skew_err  out  1  sticky: aligned column valids disagreed

## Operation
- Per-column delay line of N-1-j registers, each holding data and valid. Column N-1 is passed through without delay.
- Delay lines shift every cycle regardless of state.
- Aligned valid vector av[N-1:0] is the output of the delay lines.
  - All bits of av set: row_hit.
  - Some but not all bits set: skew_err is set and nothing is pushed. The row counter does not advance.
- FSM states and transitions:
  - IDLE -> ACTIVE on start. On that edge, row counter, overflow and skew_err are cleared.
  - ACTIVE: each row_hit pushes {row counter, aligned data} into the FIFO and increments the row counter. When the counter reaches ROWS, go to FLUSH.
  - FLUSH -> IDLE when the FIFO is empty. done is registered and pulses in the first IDLE cycle.
- row_hit outside ACTIVE is ignored: no push and no flag update.
- start outside IDLE is ignored.
- FIFO full at a push with no simultaneous pop: the row is dropped and overflow is set. The row counter still increments, so out_row exposes the gap.
- FIFO full with simultaneous push and pop: the push is accepted and overflow is not set.
- FIFO is first-word-fall-through with registered storage and no empty bypass.
  - out_data, out_row and out_last come from the head entry.
  - A pop occurs when out_valid && out_ready.
- Sticky flags hold until the next accepted start or reset.
- Reset values: out_valid, done, busy, overflow and skew_err are 0; out_data, out_row and out_last are 0; FIFO is empty; delay-line valids are 0; state is IDLE.
- Reset mid-tile discards all buffered and in-flight rows and produces no done pulse.

## Timing
- Row r element of column j must arrive at cycle T0+r+j.
- Row r is aligned in cycle T0+r+N-1 and written into the FIFO at the end of that cycle.
- out_valid rises in cycle T0+r+N if the FIFO was empty, giving a latency of N cycles from the column-0 element.
- With out_ready held at 1, sustained throughput is one row per cycle.
- The start-to-first-push gap is unconstrained; the array must not emit before start is accepted.
- The done pulse comes no earlier than one cycle after the last pop.

## Test plan
- Reset: assert rst for 2 cycles while in_valid is all ones -> all outputs 0 and busy=0. After release, no out_valid without start.
- Nominal tile (N=4, ROWS=4, FIFO_DEPTH=2, out_ready=1): start, then inject skewed C[r][j]=16r+j.
  - out_valid first rises 4 cycles after the first column-0 element.
  - Four rows come out with out_row 0..3, column j = 16r+j, and out_last on row 3.
  - done pulses once; overflow=0 and skew_err=0.
- Backpressure (same params): hold out_ready=0 for the whole tile -> rows 0 and 1 are buffered, rows 2 and 3 are dropped, and overflow=1. Releasing out_ready yields out_row 0 then 1, then done.
- Full with simultaneous pop and push: with the FIFO full, assert out_ready in the same cycle a new row aligns -> the row is accepted, overflow stays 0, and the row order is preserved.
- Skew error: delay column 2 of row 1 by one extra cycle -> skew_err=1, row 1 is not pushed, and the tile does not complete until an extra valid row arrives.
- Reset mid-ACTIVE after 2 rows pushed -> next cycle out_valid=0, busy=0, and no done. A following full tile drains correctly from out_row 0.
